// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache bus arbiter: FSM state encoding,
// bus owner encoding and sram-like transfer size constants.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_DATA = 1'b0,
    OWN_INST = 1'b1
  } arb_owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational winner select between the inst and data requesters.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin instead of
// fixed data priority with starvation override).
// Ports:
//   inst_req, data_req  requests presented this cycle
//   starve_cnt          consecutive data grants while inst waited (default build)
//   last_owner          requester granted most recently (round-robin build)
//   win_valid           at least one requester is asking
//   win_owner           selected requester
module cache_arb_pick
  import cache_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       inst_req,
  input  logic       data_req,
`ifdef CACHE_ARB_RR_EN
  input  arb_owner_e last_owner,
`else
  input  logic [3:0] starve_cnt,
`endif
  output logic       win_valid,
  output arb_owner_e win_owner
);

  logic inst_pref;

  always_comb begin
`ifdef CACHE_ARB_RR_EN
    inst_pref = (last_owner == OWN_DATA);
`else
    inst_pref = (starve_cnt >= 4'(STARVE_LIMIT));
`endif
    win_valid = inst_req | data_req;
    win_owner = OWN_DATA;
    if (inst_req && (!data_req || inst_pref)) begin
      win_owner = OWN_INST;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates an i_cache and a d_cache sram-like port onto one shared
// sram-like bus with a single outstanding transaction.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin arbitration; the
// starvation counter and STARVE_LIMIT are then unused).
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_* (in)  / inst_* (out) i_cache request / responses
//   data_* (in)  / data_* (out) d_cache request / responses
//   bus_*  (out) / bus_*  (in)  shared bus request / responses
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  arb_state_e state, state_n;
  arb_owner_e owner, owner_n;
  arb_owner_e cur_owner;
  arb_owner_e win_owner;
  logic       win_valid;
  logic       in_idle;
  logic       live;
  logic       addr_acc;
  logic       data_acc;

  assign in_idle = (state == ST_IDLE);

`ifdef CACHE_ARB_RR_EN
  // The latched owner doubles as "last granted": it only changes when a
  // new transaction is won, which is always carried to its address phase.
  cache_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_owner (owner),
    .win_valid  (win_valid),
    .win_owner  (win_owner)
  );
`else
  logic [3:0] starve_cnt, starve_cnt_n;

  cache_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .starve_cnt (starve_cnt),
    .win_valid  (win_valid),
    .win_owner  (win_owner)
  );
`endif

  // Datapath: in IDLE the combinational winner owns the bus this cycle,
  // otherwise the latched owner's live request fields are forwarded.
  // Outputs are gated by resetn so they drop immediately on reset.
  always_comb begin
    cur_owner = in_idle ? win_owner : owner;
    live      = in_idle ? win_valid : (state == ST_ADDR);
    bus_req   = resetn && live;
    if (cur_owner == OWN_INST) begin
      bus_wr    = inst_wr;
      bus_size  = inst_size;
      bus_addr  = inst_addr;
      bus_wdata = inst_wdata;
    end else begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end
    addr_acc     = resetn && live && bus_addr_ok;
    data_acc     = resetn && bus_data_ok && ((state == ST_DATA) || addr_acc);
    inst_addr_ok = addr_acc && (cur_owner == OWN_INST);
    data_addr_ok = addr_acc && (cur_owner == OWN_DATA);
    inst_data_ok = data_acc && (cur_owner == OWN_INST);
    data_data_ok = data_acc && (cur_owner == OWN_DATA);
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          owner_n = win_owner;
          if (bus_addr_ok) state_n = bus_data_ok ? ST_IDLE : ST_DATA;
          else             state_n = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus_addr_ok) state_n = bus_data_ok ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bus_data_ok) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifndef CACHE_ARB_RR_EN
  always_comb begin
    starve_cnt_n = starve_cnt;
    if (addr_acc) begin
      if (cur_owner == OWN_INST)             starve_cnt_n = '0;
      else if (inst_req && starve_cnt != '1) starve_cnt_n = starve_cnt + 4'd1;
    end else if (in_idle && !inst_req) begin
      starve_cnt_n = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) starve_cnt <= '0;
    else         starve_cnt <= starve_cnt_n;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      owner <= OWN_DATA;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;
  import cache_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the four ok outputs as {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}.
  task automatic chk_oks(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, {28'd0, exp});
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    bus_addr_ok = aok;
    bus_data_ok = dok;
    bus_rdata   = rd;
  endtask

  logic [9:0] exp_inst_seq;

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = SIZE_WORD; data_addr = '0; data_wdata = '0;
    bus(0, 0, '0);

    // Reset holds everything quiet even with requests and oks present.
    @(negedge clk);
    data_req = 1; data_addr = 32'h8000_0000; bus(1, 1, 32'h5);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk_oks("rst_oks", 4'b0000);
    @(negedge clk);
    data_req = 0; bus(0, 0, '0); resetn = 1'b1;
    #1;
    chk("idle_bus_req", bus_req, 0);

    // Inst-only read.
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0000; bus(0, 0, '0);
    #1;
    chk("i_c0_req", bus_req, 1);
    chk("i_c0_addr", bus_addr, 32'hBFC0_0000);
    chk_oks("i_c0_oks", 4'b0000);
    @(negedge clk);
    bus(1, 0, '0);
    #1;
    chk_oks("i_c1_oks", 4'b1000);
    @(negedge clk);
    inst_req = 0; bus(0, 0, '0);
    #1;
    chk("i_c2_req", bus_req, 0);
    chk_oks("i_c2_oks", 4'b0000);
    @(negedge clk);
    bus(0, 1, 32'h3C1D_0001);
    #1;
    chk_oks("i_c3_oks", 4'b0100);
    chk("i_c3_rdata", inst_rdata, 32'h3C1D_0001);

    // Simultaneous requests: data first, inst after data_data_ok.
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_addr = 32'h8000_1000; bus(1, 0, '0);
    #1;
    chk("both_addr", bus_addr, 32'h8000_1000);
    chk_oks("both_oks", 4'b0010);
    @(negedge clk);
    data_req = 0; bus(0, 1, 32'h1111_2222);
    #1;
    chk_oks("both_dok", 4'b0001);
    chk("bcast_rdata", inst_rdata, 32'h1111_2222);
    // Address and data ok in the same cycle.
    @(negedge clk);
    bus(1, 1, 32'h2222_3333);
    #1;
    chk("inst_after_addr", bus_addr, 32'hBFC0_0004);
    chk_oks("same_cyc_oks", 4'b1100);
    // Stray data ok in IDLE with no request.
    @(negedge clk);
    inst_req = 0; bus(0, 1, 32'h0);
    #1;
    chk("idle_again_req", bus_req, 0);
    chk_oks("stray_oks", 4'b0000);

    // Byte write with a delayed address ok; an inst request arriving mid-ADDR must not steal the bus.
    @(negedge clk);
    data_req = 1; data_wr = 1; data_size = SIZE_BYTE; data_addr = 32'h8000_0003; data_wdata = 32'hAB;
    bus(0, 0, '0);
    for (int unsigned c = 0; c < 5; c++) begin
      if (c == 2) begin
        inst_req = 1; inst_wr = 0; inst_addr = 32'hBFC0_0200;
      end
      #1;
      chk("wr_req", bus_req, 1);
      chk("wr_wr", bus_wr, 1);
      chk("wr_size", bus_size, SIZE_BYTE);
      chk("wr_addr", bus_addr, 32'h8000_0003);
      chk("wr_wdata", bus_wdata, 32'hAB);
      chk_oks("wr_wait_oks", 4'b0000);
      @(negedge clk);
    end
    bus(1, 0, '0);
    #1;
    chk("wr_acc_addr", bus_addr, 32'h8000_0003);
    chk_oks("wr_acc_oks", 4'b0010);
    @(negedge clk);
    data_req = 0; data_wr = 0; data_size = SIZE_WORD; inst_req = 0; bus(0, 0, '0);
    #1;
    chk("wr_data_req", bus_req, 0);
    @(negedge clk);
    bus(0, 1, '0);
    #1;
    chk_oks("wr_dok", 4'b0001);

    // Reset during DATA, then a stray data ok.
    @(negedge clk);
    data_req = 1; data_addr = 32'h8000_4000; bus(1, 0, '0);
    #1;
    chk_oks("rd_acc_oks", 4'b0010);
    @(negedge clk);
    data_req = 0; bus(0, 0, '0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 0);
    @(negedge clk);
    resetn = 1'b1; bus(0, 1, 32'h9);
    #1;
    chk_oks("post_rst_stray", 4'b0000);

    // Continuous requests from both sides, one-cycle transactions.
`ifdef CACHE_ARB_RR_EN
    exp_inst_seq = 10'b01_0101_0101;
`else
    exp_inst_seq = 10'b10_0001_0000;
`endif
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC0_0100;
    data_req = 1; data_addr = 32'h8000_2000; bus(1, 1, '0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("seq%0d_addr", k), bus_addr, exp_inst_seq[k] ? 32'hBFC0_0100 : 32'h8000_2000);
      chk_oks($sformatf("seq%0d_oks", k), exp_inst_seq[k] ? 4'b1100 : 4'b0011);
      @(negedge clk);
    end
    inst_req = 0; data_req = 0; bus(0, 0, '0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, max consecutive data grants while an inst request waits (range 1..15).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 inst_req, inst_wr, inst_size[1:0], inst_addr[31:0], inst_wdata[31:0]  in  sram-like inst requester (i_cache side).
REQ-005 inst_rdata[31:0], inst_addr_ok, inst_data_ok  out  responses to inst requester.
REQ-006 data_req, data_wr, data_size[1:0], data_addr[31:0], data_wdata[31:0]  in  sram-like data requester (d_cache side).
REQ-007 data_rdata[31:0], data_addr_ok, data_data_ok  out  responses to data requester.
REQ-008 bus_req, bus_wr, bus_size[1:0], bus_addr[31:0], bus_wdata[31:0]  out  shared sram-like bus to AXI bridge.
REQ-009 bus_rdata[31:0], bus_addr_ok, bus_data_ok  in  bus responses.

Function
REQ-010 One outstanding transaction total; states IDLE, ADDR, DATA (2-bit encoding).
REQ-011 IDLE: winner chosen combinationally same cycle; bus_* driven from winner's request fields; no request -> bus_req=0.
REQ-012 Default priority data over inst, overridden per REQ-017.
REQ-013 IDLE, winner present: owner latched; bus_addr_ok=1 -> DATA (or IDLE if bus_data_ok also 1); else -> ADDR.
REQ-014 ADDR: bus_* driven from latched owner's live inputs; requester holds req stable until addr_ok; bus_addr_ok -> DATA (or IDLE if bus_data_ok same cycle).
REQ-015 DATA: bus_req=0; bus_data_ok -> IDLE; new arbitration starts in the IDLE cycle following, zero-bubble not required.
REQ-016 bus_addr_ok/bus_data_ok forwarded only to owner (IDLE: combinational winner); non-owner *_addr_ok/*_data_ok = 0; bus_rdata broadcast to both *_rdata unconditionally.
REQ-017 Starvation counter: +1 on each data grant (addr_ok accepted) while inst_req high; at STARVE_LIMIT inst wins next arbitration; cleared on inst grant or when inst_req low in IDLE; saturates, never wraps.
REQ-018 Owner change only in IDLE; requester dropping req in ADDR is protocol violation, arbiter keeps owner until addr_ok.
REQ-019 bus_data_ok in IDLE with no request: ignored, no ok forwarded.

Reset
REQ-020 resetn low: state=IDLE, owner=data, counter=0, all *_addr_ok, *_data_ok, bus_req low immediately (asynchronous).
REQ-021 Reset mid-transaction abandons it; no data_ok later forwarded for it; bridge reset together.

Configuration
REQ-022 Macro CACHE_ARB_RR_EN defined: round-robin — winner is the requester not granted last when both request; starvation counter absent; STARVE_LIMIT ignored.
REQ-023 Macro undefined: fixed data priority with starvation counter per REQ-012/REQ-017.

Structure
REQ-024 Shared package holds state enum (IDLE/ADDR/DATA), owner encoding (OWN_DATA=0, OWN_INST=1), SIZE_BYTE/HALF/WORD constants.
REQ-025 One sub-module natural: cache_arb_pick (combinational winner select incl. starvation/RR logic); datapath muxing stays in top.

Verification
REQ-026 Inst only: inst_req addr 0xBFC00000, bus_addr_ok cycle 1, bus_data_ok cycle 3 rdata 0x3C1D0001 -> inst_addr_ok at cycle 1, inst_data_ok + inst_rdata=0x3C1D0001 at cycle 3, data_* oks stay 0.
REQ-027 Both request same cycle IDLE (default mode) -> data granted, bus_addr=data_addr 0x80001000; inst granted after data_data_ok.
REQ-028 Continuous both requests, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-029 Write: data_req wr=1 size=0 addr 0x80000003 wdata 0xAB, addr_ok delayed 5 cycles -> bus_wr=1, bus_size=0, fields stable through ADDR, data_addr_ok coincident with bus_addr_ok.
REQ-030 addr_ok and data_ok same cycle -> owner gets both same cycle, state IDLE next.
REQ-031 resetn low during DATA then released, later stray bus_data_ok -> no ok forwarded; CACHE_ARB_RR_EN build: both requesting -> alternating I,D,I,D.
